// File: rtl/ysyx_22051468_div_unit_pkg.sv
// Shared definitions for the iterative divider: datapath width, FSM encoding,
// iteration counts and a word sign-extension helper.
package ysyx_22051468_div_unit_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [6:0] ITER_D = 7'd64;
    localparam logic [6:0] ITER_W = 7'd32;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22051468_div_step.sv
// One restoring-division step: shift {rem, quo} left by one, trial-subtract
// the divisor and keep the difference when it does not borrow.
module ysyx_22051468_div_step
    import ysyx_22051468_div_unit_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    // One extra bit keeps the shifted remainder exact for full-width divisors;
    // the top bit of the difference is the borrow.
    always_comb begin
        shifted  = {rem, quo[XLEN-1]};
        diff     = shifted - {1'b0, divisor};
        fits     = ~diff[XLEN];
        rem_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], fits};
    end

endmodule

// File: rtl/ysyx_22051468_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU and their W forms,
// with valid/ready on both sides and a synchronous flush.
module ysyx_22051468_div_unit
    import ysyx_22051468_div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_rem,
    input  logic            is_U,
    input  logic            is_W,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    div_state_t      state;
    logic [6:0]      counter;
    logic [XLEN-1:0] rem_reg, quo_reg, div_reg;
    logic [XLEN-1:0] rem_next, quo_next;
    logic            rem_sel, w_sel, q_neg, r_neg;

    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg;
    logic [XLEN-1:0] special_r, special_val;
    logic [XLEN-1:0] q_fix, r_fix, sel_val, final_val;
    logic            a_neg, b_neg, div_zero, overflow;

    assign in_ready = (state == IDLE);

    ysyx_22051468_div_step u_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (div_reg),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Operand preparation: W operands are narrowed to 32 bits (sign- or
    // zero-extended by signedness) so the magnitude and special-case logic
    // is shared between widths.
    always_comb begin
        a_ext = dividend;
        b_ext = divisor;
        if (is_W) begin
            a_ext = is_U ? {{(XLEN-32){1'b0}}, dividend[31:0]} : sext32(dividend[31:0]);
            b_ext = is_U ? {{(XLEN-32){1'b0}}, divisor[31:0]}  : sext32(divisor[31:0]);
        end
        a_neg       = ~is_U & a_ext[XLEN-1];
        b_neg       = ~is_U & b_ext[XLEN-1];
        a_mag       = a_neg ? -a_ext : a_ext;
        b_mag       = b_neg ? -b_ext : b_ext;
        min_neg     = is_W ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero    = (b_ext == '0);
        overflow    = ~is_U & (a_ext == min_neg) & (b_ext == '1);
        special_r   = is_W ? sext32(dividend[31:0]) : dividend;
        if (div_zero)
            special_val = is_rem ? special_r : '1;
        else
            special_val = is_rem ? '0 : special_r;
    end

    // Result of the final step, with sign fix and word sign-extension.
    always_comb begin
        q_fix     = q_neg ? -quo_next : quo_next;
        r_fix     = r_neg ? -rem_next : rem_next;
        sel_val   = rem_sel ? r_fix : q_fix;
        final_val = w_sel ? sext32(sel_val[31:0]) : sel_val;
    end

    // W dividends are placed in the upper half of the quotient register so
    // that 32 shifts bring every dividend bit through the remainder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            div_reg   <= '0;
            rem_sel   <= 1'b0;
            w_sel     <= 1'b0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem_sel <= is_rem;
                        w_sel   <= is_W;
                        q_neg   <= a_neg ^ b_neg;
                        r_neg   <= a_neg;
                        if (div_zero || overflow) begin
                            result    <= special_val;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            rem_reg <= '0;
                            quo_reg <= is_W ? (a_mag << 32) : a_mag;
                            div_reg <= b_mag;
                            counter <= is_W ? ITER_W : ITER_D;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    counter <= counter - 7'd1;
                    if (counter == 7'd1) begin
                        result    <= final_val;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
